dma_tohost_arb: RTL and testbench

- Packet-level round-robin arbiter that shares the single tohost DMA stream between NUM_SRC 64-bit AXI-stream producers (e.g. per-channel FIFOs).
- Its output feeds the 64-to-32 tohost width converter in front of the AXI DMA.
- Grant is locked from the first beat of a packet until its tlast beat is accepted, so packets never interleave.
- Granted source id is exported alongside the data for downstream tagging.

---
 rtl/dma_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 18 +
 rtl/dma_tohost_arb.sv | 118 +++++++++++
 tb/tb_dma_tohost_arb.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA stream blocks: FSM encodings, AXIS widths
// and the round-robin pick function used by the arbiters.
package dma_pkg;

   localparam logic [1:0] ARB_S_IDLE = 2'b00;
   localparam logic [1:0] ARB_S_XFER = 2'b01;

   localparam int AXIS_DATA_W = 64;
   localparam int AXIS_KEEP_W = 8;

   // rr_pick works on a fixed 8-wide request vector; callers zero-extend.
   localparam int MAX_SRC = 8;

   // Walk from last+n down to last+1 so the nearest set bit after last wins;
   // last itself is only chosen when it is the sole requester.
   function automatic logic [2:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                          input logic [2:0]         last,
                                          input int                 n);
      logic [2:0] win;
      logic [2:0] idx;
      win = last;
      for (int k = n; k >= 1; k--) begin
         idx = 3'((32'(last) + 32'(k)) % 32'(n));
         if (req[idx]) win = idx;
      end
      return win;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority picker: returns the first requester
// after last_grant (wrapping) and whether any request was present.
module rr_arbiter
   import dma_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [ID_W-1:0]    last_grant,
   output logic [ID_W-1:0]    grant,
   output logic               found
);

   assign grant = ID_W'(rr_pick(MAX_SRC'(req), 3'(last_grant), NUM_SRC));
   assign found = |req;

endmodule

// File: rtl/dma_tohost_arb.sv
// Packet-level round-robin arbiter sharing the tohost DMA stream between
// NUM_SRC AXIS producers. Define DMA_TOHOST_ARB_STATS_EN for per-source packet counters.
module dma_tohost_arb
   import dma_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int ID_W    = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_SRC-1:0]             src_en,
   input  logic [NUM_SRC-1:0]             s_axis_tvalid,
   input  logic [AXIS_DATA_W*NUM_SRC-1:0] s_axis_tdata,
   input  logic [AXIS_KEEP_W*NUM_SRC-1:0] s_axis_tkeep,
   input  logic [NUM_SRC-1:0]             s_axis_tlast,
   output logic [NUM_SRC-1:0]             s_axis_tready,
   output logic                           m_axis_tvalid,
   output logic [AXIS_DATA_W-1:0]         m_axis_tdata,
   output logic [AXIS_KEEP_W-1:0]         m_axis_tkeep,
   output logic                           m_axis_tlast,
   output logic [ID_W-1:0]                m_axis_tid,
   input  logic                           m_axis_tready,
   output logic                           arb_busy
`ifdef DMA_TOHOST_ARB_STATS_EN
   ,
   input  logic                           stats_clr,
   output logic [16*NUM_SRC-1:0]          pkt_cnt
`endif
);

   logic [1:0]      state;
   logic [1:0]      state_next;
   logic [ID_W-1:0] grant;
   logic [ID_W-1:0] last_grant;
   logic [ID_W-1:0] pick;
   logic            found;
   logic            beat_last;

   logic [AXIS_DATA_W-1:0] src_data [NUM_SRC];
   logic [AXIS_KEEP_W-1:0] src_keep [NUM_SRC];

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
      assign src_data[i] = s_axis_tdata[AXIS_DATA_W*i +: AXIS_DATA_W];
      assign src_keep[i] = s_axis_tkeep[AXIS_KEEP_W*i +: AXIS_KEEP_W];
   end

   rr_arbiter #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) u_rr (
      .req        (s_axis_tvalid & src_en),
      .last_grant (last_grant),
      .grant      (pick),
      .found      (found)
   );

   assign beat_last = (state == ARB_S_XFER) & m_axis_tvalid & m_axis_tready & m_axis_tlast;

   // last_grant starts at the top source so source 0 wins the first arbitration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB_S_IDLE;
         grant      <= '0;
         last_grant <= ID_W'(NUM_SRC - 1);
      end else begin
         state <= state_next;
         if (state == ARB_S_IDLE && found) grant <= pick;
         if (beat_last) last_grant <= grant;
      end
   end

   always_comb begin
      state_next = ARB_S_IDLE;
      case (state)
         ARB_S_IDLE: state_next = found ? ARB_S_XFER : ARB_S_IDLE;
         ARB_S_XFER: state_next = beat_last ? ARB_S_IDLE : ARB_S_XFER;
         default:    state_next = ARB_S_IDLE;
      endcase
   end

   // Outside a granted packet everything sits at its reset value.
   always_comb begin
      s_axis_tready = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tlast  = 1'b0;
      m_axis_tid    = '0;
      arb_busy      = 1'b0;
      if (state == ARB_S_XFER) begin
         m_axis_tvalid        = s_axis_tvalid[grant];
         m_axis_tdata         = src_data[grant];
         m_axis_tkeep         = src_keep[grant];
         m_axis_tlast         = s_axis_tlast[grant];
         m_axis_tid           = grant;
         arb_busy             = 1'b1;
         s_axis_tready[grant] = m_axis_tready;
      end
   end

`ifdef DMA_TOHOST_ARB_STATS_EN
   // Clear takes priority over a coincident packet completion.
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_stats
      logic [15:0] cnt;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt <= '0;
         end else if (stats_clr) begin
            cnt <= '0;
         end else if (beat_last && grant == ID_W'(i)) begin
            cnt <= cnt + 16'd1;
         end
      end
      assign pkt_cnt[16*i +: 16] = cnt;
   end
`endif

endmodule

// File: tb/tb_dma_tohost_arb.sv
// Scoreboard bench for dma_tohost_arb: per-source beat drivers, a negedge
// monitor checking accepted beats in hand-computed grant order.
module tb_dma_tohost_arb;

   localparam int NUM_SRC = 4;
   localparam int ID_W    = 2;

   typedef struct packed {
      logic [1:0]  id;
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } beat_t;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [NUM_SRC-1:0]     src_en;
   logic [NUM_SRC-1:0]     s_axis_tvalid;
   logic [64*NUM_SRC-1:0]  s_axis_tdata;
   logic [8*NUM_SRC-1:0]   s_axis_tkeep;
   logic [NUM_SRC-1:0]     s_axis_tlast;
   logic [NUM_SRC-1:0]     s_axis_tready;
   logic                   m_axis_tvalid;
   logic [63:0]            m_axis_tdata;
   logic [7:0]             m_axis_tkeep;
   logic                   m_axis_tlast;
   logic [ID_W-1:0]        m_axis_tid;
   logic                   m_axis_tready;
   logic                   arb_busy;
`ifdef DMA_TOHOST_ARB_STATS_EN
   logic                   stats_clr;
   logic [16*NUM_SRC-1:0]  pkt_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   beat_t expq[$];
   int    beats_seen = 0;
   int    cyc        = 0;
   int    end_cyc    = 0;
   int    gap_min    = 999;
   int    gap_max    = 0;
   bit    have_end   = 1'b0;
   bit    in_pkt     = 1'b0;

   logic [63:0] drv_data [NUM_SRC][32];
   logic [7:0]  drv_keep [NUM_SRC][32];
   logic        drv_last [NUM_SRC][32];
   int          rd [NUM_SRC];
   int          wr [NUM_SRC];

   dma_tohost_arb #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .src_en        (src_en),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tid    (m_axis_tid),
      .m_axis_tready (m_axis_tready),
      .arb_busy      (arb_busy)
`ifdef DMA_TOHOST_ARB_STATS_EN
      ,
      .stats_clr     (stats_clr),
      .pkt_cnt       (pkt_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] beatData(input int src, input int seq, input int beat);
      return {8'(src), 8'(seq), 8'(beat), 8'hA5, 24'hC0FFEE, 8'(seq ^ (beat * 3))};
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Queue a packet in a source's beat store; non-last beats carry keep ff.
   task automatic applyStimulus(input int src, input int nbeats, input logic [7:0] last_keep, input int seq);
      for (int b = 0; b < nbeats; b++) begin
         drv_data[src][wr[src]] = beatData(src, seq, b);
         drv_keep[src][wr[src]] = (b == nbeats - 1) ? last_keep : 8'hFF;
         drv_last[src][wr[src]] = (b == nbeats - 1);
         wr[src]++;
      end
   endtask

   task automatic expectPacket(input int src, input int nbeats, input logic [7:0] last_keep, input int seq);
      beat_t e;
      for (int b = 0; b < nbeats; b++) begin
         e.id   = 2'(src);
         e.data = beatData(src, seq, b);
         e.keep = (b == nbeats - 1) ? last_keep : 8'hFF;
         e.last = (b == nbeats - 1);
         expq.push_back(e);
      end
   endtask

   task automatic flushBench();
      for (int i = 0; i < NUM_SRC; i++) begin
         rd[i] = 0;
         wr[i] = 0;
      end
      expq.delete();
      beats_seen = 0;
      have_end   = 1'b0;
      in_pkt     = 1'b0;
      gap_min    = 999;
      gap_max    = 0;
   endtask

   task automatic resetDut();
      @(posedge clk); #2;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      flushBench();
      checkOutput("reset_state", {s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep,
                                  m_axis_tlast, m_axis_tid, arb_busy}, '0);
      @(posedge clk); #2;
      rst_n = 1'b1;
   endtask

   task automatic waitBeats(input int n, input string name);
      int c;
      c = 0;
      while (beats_seen < n && c < 400) begin
         @(posedge clk);
         c++;
      end
      #2;
      checkOutput(name, beats_seen >= n, 1);
   endtask

   task automatic waitValid(input string name);
      int c;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!m_axis_tvalid && c < 100);
      checkOutput(name, m_axis_tvalid, 1);
   endtask

   // Sources present their head beat and advance once the handshake was seen.
   initial begin : driver
      logic [NUM_SRC-1:0] acc;
      for (int i = 0; i < NUM_SRC; i++) begin
         rd[i] = 0;
         wr[i] = 0;
      end
      s_axis_tvalid = '0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tlast  = '0;
      forever begin
         @(negedge clk);
         acc = s_axis_tvalid & s_axis_tready;
         @(posedge clk); #1;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (acc[i] && rd[i] < wr[i]) rd[i]++;
            if (rd[i] < wr[i]) begin
               s_axis_tvalid[i]         = 1'b1;
               s_axis_tdata[64*i +: 64] = drv_data[i][rd[i]];
               s_axis_tkeep[8*i +: 8]   = drv_keep[i][rd[i]];
               s_axis_tlast[i]          = drv_last[i][rd[i]];
            end else begin
               s_axis_tvalid[i]         = 1'b0;
               s_axis_tdata[64*i +: 64] = '0;
               s_axis_tkeep[8*i +: 8]   = '0;
               s_axis_tlast[i]          = 1'b0;
            end
         end
      end
   end

   // Accepted beats pop the scoreboard; stalled beats must match its head.
   always @(negedge clk) begin : monitor
      beat_t got;
      cyc++;
      if (rst_n && m_axis_tvalid) begin
         got = '{id: m_axis_tid, data: m_axis_tdata, keep: m_axis_tkeep, last: m_axis_tlast};
         if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_beat: got %0h expected none", got);
         end else if (m_axis_tready) begin
            checkOutput("beat", got, expq.pop_front());
            beats_seen++;
            if (!in_pkt && have_end) begin
               if (cyc - end_cyc < gap_min) gap_min = cyc - end_cyc;
               if (cyc - end_cyc > gap_max) gap_max = cyc - end_cyc;
            end
            in_pkt = !m_axis_tlast;
            if (m_axis_tlast) begin
               have_end = 1'b1;
               end_cyc  = cyc;
            end
         end else begin
            checkOutput("held_beat", got, expq[0]);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      logic [5:0] bp_pat;
      rst_n         = 1'b1;
      m_axis_tready = 1'b1;
      src_en        = '1;
`ifdef DMA_TOHOST_ARB_STATS_EN
      stats_clr     = 1'b0;
`endif
      #1 rst_n = 1'b0;
      resetDut();

      // Single source, 3 beats, partial keep on the last beat.
      expectPacket(2, 3, 8'h0F, 1);
      applyStimulus(2, 3, 8'h0F, 1);
      begin
         int c;
         c = 0;
         do begin
            @(negedge clk);
            c++;
         end while (!s_axis_tvalid[2] && c < 100);
      end
      #1 checkOutput("latency_n", m_axis_tvalid, 0);
      @(negedge clk); #1;
      checkOutput("latency_n1", {m_axis_tvalid, m_axis_tid, arb_busy}, {1'b1, 2'd2, 1'b1});
      waitBeats(3, "single_done");
      @(negedge clk); #1;
      checkOutput("busy_after_last", {arb_busy, m_axis_tvalid}, 0);
      checkOutput("single_drain", expq.size(), 0);

      // Fairness: all sources loaded, grant order 0,1,2,3,0,1.
      resetDut();
      applyStimulus(0, 2, 8'hFF, 10);
      applyStimulus(0, 2, 8'h00, 11);
      applyStimulus(1, 2, 8'hFF, 20);
      applyStimulus(1, 2, 8'h3F, 21);
      applyStimulus(2, 2, 8'h01, 30);
      applyStimulus(3, 2, 8'hFF, 40);
      expectPacket(0, 2, 8'hFF, 10);
      expectPacket(1, 2, 8'hFF, 20);
      expectPacket(2, 2, 8'h01, 30);
      expectPacket(3, 2, 8'hFF, 40);
      expectPacket(0, 2, 8'h00, 11);
      expectPacket(1, 2, 8'h3F, 21);
      waitBeats(12, "fair_done");
      checkOutput("bubble_min", gap_min, 2);
      checkOutput("bubble_max", gap_max, 2);
      checkOutput("fair_drain", expq.size(), 0);

      // Backpressure on a 4-beat packet from source 1.
      resetDut();
      bp_pat = 6'b111001;
      m_axis_tready = 1'b1;
      expectPacket(1, 4, 8'hFF, 50);
      applyStimulus(1, 4, 8'hFF, 50);
      waitValid("bp_start");
      #1 checkOutput("bp_tready_0", s_axis_tready, 4'b0010);
      for (int k = 1; k < 6; k++) begin
         @(posedge clk); #2;
         m_axis_tready = bp_pat[k];
         @(negedge clk); #1;
         checkOutput($sformatf("bp_tready_%0d", k), s_axis_tready, bp_pat[k] ? 4'b0010 : 4'b0000);
      end
      m_axis_tready = 1'b1;
      waitBeats(4, "bp_done");
      checkOutput("bp_drain", expq.size(), 0);

      // Mask: only 1 and 3 eligible; source 1 dropped mid-packet.
      resetDut();
      src_en = 4'b1010;
      applyStimulus(0, 2, 8'hFF, 60);
      applyStimulus(2, 2, 8'hFF, 61);
      applyStimulus(1, 2, 8'hFF, 70);
      applyStimulus(1, 2, 8'hFF, 71);
      applyStimulus(1, 2, 8'hFF, 72);
      applyStimulus(3, 2, 8'hFF, 80);
      applyStimulus(3, 2, 8'h00, 81);
      applyStimulus(3, 2, 8'h0F, 82);
      expectPacket(1, 2, 8'hFF, 70);
      expectPacket(3, 2, 8'hFF, 80);
      expectPacket(1, 2, 8'hFF, 71);
      expectPacket(3, 2, 8'h00, 81);
      expectPacket(3, 2, 8'h0F, 82);
      waitBeats(5, "mask_mid");
      src_en = 4'b1000;
      waitBeats(10, "mask_done");
      repeat (8) @(posedge clk);
      #2;
      checkOutput("mask_drain", expq.size(), 0);
      src_en = '1;

      // Asynchronous reset during beat 2 of a packet from source 3.
      resetDut();
      expectPacket(3, 4, 8'hFF, 90);
      applyStimulus(3, 4, 8'hFF, 90);
      waitBeats(1, "rst_beat1");
      #1 rst_n = 1'b0;
      #1 checkOutput("async_reset", {s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep,
                                     m_axis_tlast, m_axis_tid, arb_busy}, '0);
      @(posedge clk); #2;
      flushBench();
      @(posedge clk); #2;
      rst_n = 1'b1;
      applyStimulus(3, 2, 8'hFF, 91);
      applyStimulus(0, 2, 8'hFF, 92);
      expectPacket(0, 2, 8'hFF, 92);
      expectPacket(3, 2, 8'hFF, 91);
      waitBeats(4, "rst_after");
      checkOutput("rst_drain", expq.size(), 0);

`ifdef DMA_TOHOST_ARB_STATS_EN
      // Packet counters: five from source 0, two from source 1.
      resetDut();
      for (int p = 0; p < 5; p++) applyStimulus(0, 1, 8'hFF, 100 + p);
      for (int p = 0; p < 2; p++) applyStimulus(1, 1, 8'hFF, 110 + p);
      expectPacket(0, 1, 8'hFF, 100);
      expectPacket(1, 1, 8'hFF, 110);
      expectPacket(0, 1, 8'hFF, 101);
      expectPacket(1, 1, 8'hFF, 111);
      expectPacket(0, 1, 8'hFF, 102);
      expectPacket(0, 1, 8'hFF, 103);
      expectPacket(0, 1, 8'hFF, 104);
      waitBeats(7, "stats_done");
      checkOutput("pkt_cnt0", pkt_cnt[15:0], 16'd5);
      checkOutput("pkt_cnt1", pkt_cnt[31:16], 16'd2);
      expectPacket(1, 1, 8'hFF, 120);
      applyStimulus(1, 1, 8'hFF, 120);
      waitValid("stats_clr_beat");
      #1 stats_clr = 1'b1;
      @(posedge clk); #2;
      stats_clr = 1'b0;
      checkOutput("pkt_cnt_clr", pkt_cnt[31:0], 32'd0);
      expectPacket(1, 1, 8'hFF, 121);
      applyStimulus(1, 1, 8'hFF, 121);
      waitBeats(9, "stats_after");
      @(negedge clk); #1;
      checkOutput("pkt_cnt1_after", pkt_cnt[31:16], 16'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
